// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular buffer of {inst, pc}
// entries with registered dequeue outputs and a flush from the ROB.
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_S,
    input  logic [31:0] IF_Inst,
    input  logic [31:0] IF_pc,
    output logic        IQ_full,
    input  logic        Dec_stall,
    output logic        Dec_S,
    output logic [31:0] Dec_Inst,
    output logic [31:0] Dec_pc,
    input  logic        ROB_Jump_S
);

    localparam logic [PTR_W:0] CNT_FULL   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ALMOST = (PTR_W + 1)'(DEPTH - 1);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             dec_s_q, dec_s_d;
    logic [31:0]      dec_inst_q, dec_inst_d;
    logic [31:0]      dec_pc_q, dec_pc_d;
    logic             push, pop;

    // A flush swallows any push or pop presented on the same edge.
    assign push = IF_S && (count_q != CNT_FULL) && !ROB_Jump_S;
    assign pop  = rdy && !Dec_stall && (count_q != '0) && !ROB_Jump_S;

    // One slot of margin because fetch's strobe is registered a cycle late.
    assign IQ_full  = (count_q >= CNT_ALMOST);
    assign Dec_S    = dec_s_q;
    assign Dec_Inst = dec_inst_q;
    assign Dec_pc   = dec_pc_q;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        dec_s_d    = 1'b0;
        dec_inst_d = dec_inst_q;
        dec_pc_d   = dec_pc_q;
        if (ROB_Jump_S) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d                 = head_q + PTR_W'(1);
                dec_s_d                = 1'b1;
                {dec_inst_d, dec_pc_d} = mem_q[head_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            dec_s_q    <= 1'b0;
            dec_inst_q <= '0;
            dec_pc_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            dec_s_q    <= dec_s_d;
            dec_inst_q <= dec_inst_d;
            dec_pc_q   <= dec_pc_d;
        end
    end

    // Entry storage is never cleared; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= {IF_Inst, IF_pc};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: accepted pushes are queued as expected
// {inst, pc} words and popped whenever the DUT raises Dec_S.
module tb_inst_queue;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        IF_S;
    logic [31:0] IF_Inst;
    logic [31:0] IF_pc;
    logic        IQ_full;
    logic        Dec_stall;
    logic        Dec_S;
    logic [31:0] Dec_Inst;
    logic [31:0] Dec_pc;
    logic        ROB_Jump_S;

    logic [63:0] sb [$];
    logic [63:0] lastOut;
    int          mcount;
    int          nVectors;
    int          nMiscompares;

    inst_queue #(.DEPTH(DEPTH), .PTR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .IF_S       (IF_S),
        .IF_Inst    (IF_Inst),
        .IF_pc      (IF_pc),
        .IQ_full    (IQ_full),
        .Dec_stall  (Dec_stall),
        .Dec_S      (Dec_S),
        .Dec_Inst   (Dec_Inst),
        .Dec_pc     (Dec_pc),
        .ROB_Jump_S (ROB_Jump_S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of stimulus; the model decides pop/push eligibility from the
    // pre-edge count, so a push into an empty queue is never seen the same edge.
    task automatic applyStimulus(input logic ifS, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic stall, input logic rdyV, input logic jump);
        logic expPop;
        logic expPush;
        IF_S       = ifS;
        IF_Inst    = inst;
        IF_pc      = pc;
        Dec_stall  = stall;
        rdy        = rdyV;
        ROB_Jump_S = jump;
        expPop  = rdyV && !stall && (mcount != 0) && !jump;
        expPush = ifS && (mcount < DEPTH) && !jump;
        @(posedge clk);
        #1;
        checkOutput("dec_s", 64'(Dec_S), 64'(expPop));
        if (jump) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (Dec_S) begin
                if (sb.size() > 0) lastOut = sb.pop_front();
                else checkOutput("dec_from_empty", 64'(Dec_S), 64'd0);
            end
            if (expPop) mcount--;
            if (expPush) begin
                sb.push_back({inst, pc});
                mcount++;
            end
        end
        checkOutput("dec_data", {Dec_Inst, Dec_pc}, lastOut);
        checkOutput("iq_full", 64'(IQ_full), 64'(mcount >= DEPTH - 1));
    endtask

    task automatic idle(input int n, input logic stall, input logic rdyV);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, stall, rdyV, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dec_s"}, 64'(Dec_S), 64'd0);
        checkOutput({tag, "_dec_data"}, {Dec_Inst, Dec_pc}, 64'd0);
        checkOutput({tag, "_iq_full"}, 64'(IQ_full), 64'd0);
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        mcount       = 0;
        lastOut      = '0;
        rst          = 1'b1;
        rdy          = 1'b1;
        IF_S         = 1'b0;
        IF_Inst      = '0;
        IF_pc        = '0;
        Dec_stall    = 1'b0;
        ROB_Jump_S   = 1'b0;

        #2 rst = 1'b0;
        #1 checkResetState("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] basic push/pop");
        applyStimulus(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0, 1'b1);

        $display("[TB] fill with decoder stalled");
        for (int i = 0; i < 17; i++)
            applyStimulus(1'b1, $urandom, 32'(i * 4), 1'b1, 1'b1, 1'b0);
        idle(18, 1'b0, 1'b1);

        $display("[TB] random push/pop with wrap");
        for (int i = 0; i < 40; i++)
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                          ($urandom_range(0, 2) == 0), 1'b1, 1'b0);
        idle(20, 1'b0, 1'b1);

        $display("[TB] flush with simultaneous push");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, $urandom, 32'h100 + 32'(i * 4), 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h200, 1'b0, 1'b1, 1'b1);
        idle(6, 1'b0, 1'b1);

        $display("[TB] rdy low freezes pops");
        applyStimulus(1'b1, 32'hAAAA_0001, 32'h300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hAAAA_0002, 32'h304, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0, 1'b1);

        $display("[TB] async reset mid-operation");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, $urandom, 32'h400 + 32'(i * 4), 1'b1, 1'b1, 1'b0);
        #3 rst = 1'b0;
        #1 checkResetState("async_reset");
        sb.delete();
        mcount  = 0;
        lastOut = '0;
        #2 rst = 1'b1;
        applyStimulus(1'b1, 32'h5555_0000, 32'h500, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0, 1'b1);

        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
